// File: rtl/pos_cache_pkg.sv
// pos_cache_pkg: shared widths, FSM and tag types, and the max-count helper
// for the position-cache sweep reader.
package pos_cache_pkg;
    localparam int DEF_OFFSET_WIDTH = 29;
    localparam int DEF_ADDR_WIDTH   = 7;
    localparam int DEF_NUM_CELLS    = 14;
    localparam int DEF_PARTICLE_NUM = 127;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] id;
        logic [DEF_NUM_CELLS-1:0]  mask;
    } tag_t;

    function automatic logic [DEF_ADDR_WIDTH-1:0] max_count_f(
        input logic [DEF_NUM_CELLS*DEF_ADDR_WIDTH-1:0] counts
    );
        logic [DEF_ADDR_WIDTH-1:0] m;
        m = '0;
        for (int c = 0; c < DEF_NUM_CELLS; c++)
            m = counts[c*DEF_ADDR_WIDTH +: DEF_ADDR_WIDTH] > m ? counts[c*DEF_ADDR_WIDTH +: DEF_ADDR_WIDTH] : m;
        return m;
    endfunction
endpackage

// File: rtl/pos_cache_sweep_reader_fifo.sv
// pos_sweep_fifo: small synchronous FIFO buffering tagged sweep results
// ahead of the force-pipeline consumer.
module pos_sweep_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc_f(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= inc_f(wr_q);
            if (do_pop) rd_q <= inc_f(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/pos_cache_sweep_reader.sv
// pos_cache_sweep_reader: sweeps particle ids across NUM_CELLS position caches in
// lockstep and streams per-cell masked positions under valid/ready backpressure.
module pos_cache_sweep_reader
    import pos_cache_pkg::*;
#(
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter int DATA_WIDTH   = 3 * OFFSET_WIDTH,
    parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = RD_LATENCY + 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [DEF_NUM_CELLS*DEF_ADDR_WIDTH-1:0] cell_count,
    output logic                                 busy,
    output logic                                 done,
    output logic [DEF_ADDR_WIDTH-1:0]            cache_addr,
    output logic                                 cache_rden,
    input  logic [DEF_NUM_CELLS*DATA_WIDTH-1:0]  cache_q,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DEF_ADDR_WIDTH-1:0]            out_particle_id,
    output logic [DEF_NUM_CELLS-1:0]             out_cell_mask,
    output logic [DEF_NUM_CELLS*DATA_WIDTH-1:0]  out_pos_data
);
    localparam int NUM_CELLS  = DEF_NUM_CELLS;
    localparam int ADDR_WIDTH = DEF_ADDR_WIDTH;
    localparam int FW = $bits(tag_t) + NUM_CELLS * DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LATENCY + 1);

    state_t state_q, state_d;
    logic [NUM_CELLS*ADDR_WIDTH-1:0] counts_q, clamped;
    logic [ADDR_WIDTH-1:0]           max_q, rd_ptr_q;
    logic [IW-1:0]                   inflight_q;
    logic [RD_LATENCY-1:0]           vld_q;
    tag_t [RD_LATENCY-1:0]           tag_q;
    logic [NUM_CELLS-1:0]            issue_mask;
    logic [NUM_CELLS*DATA_WIDTH-1:0] pos_masked;
    logic [FW-1:0]                   fifo_dout;
    logic [CW-1:0]                   fifo_cnt;
    logic                            fifo_full, fifo_empty, issue, ret, pop;
    tag_t                            ret_tag;

    assign ret     = vld_q[RD_LATENCY-1];
    assign ret_tag = tag_q[RD_LATENCY-1];
    assign pop     = out_valid && out_ready;
    // Credit: every outstanding read already owns a FIFO slot, so overflow is impossible.
    assign issue   = state_q == ISSUE && max_q != '0 && !fifo_full
                     && int'(inflight_q) + int'(fifo_cnt) < FIFO_DEPTH;

    always_comb begin
        clamped    = '0;
        issue_mask = '0;
        pos_masked = '0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            clamped[c*ADDR_WIDTH +: ADDR_WIDTH] = cell_count[c*ADDR_WIDTH +: ADDR_WIDTH] > ADDR_WIDTH'(PARTICLE_NUM)
                ? ADDR_WIDTH'(PARTICLE_NUM) : cell_count[c*ADDR_WIDTH +: ADDR_WIDTH];
            issue_mask[c] = rd_ptr_q < counts_q[c*ADDR_WIDTH +: ADDR_WIDTH];
            pos_masked[c*DATA_WIDTH +: DATA_WIDTH] = ret_tag.mask[c] ? cache_q[c*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ISSUE : IDLE;
            ISSUE:   state_d = max_q == '0 ? FINISH : (issue && rd_ptr_q == max_q - 1'b1) ? DRAIN : ISSUE;
            DRAIN:   state_d = inflight_q == '0 && (fifo_empty || (fifo_cnt == CW'(1) && pop)) ? FINISH : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = state_q == ISSUE || state_q == DRAIN;
        done       = state_q == FINISH;
        cache_rden = issue;
        cache_addr = issue ? rd_ptr_q : '0;
        out_valid  = !fifo_empty;
        {out_particle_id, out_cell_mask, out_pos_data} = out_valid ? fifo_dout : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            counts_q   <= '0;
            max_q      <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            vld_q      <= '0;
            tag_q      <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                counts_q <= clamped;
                max_q    <= max_count_f(clamped);
                rd_ptr_q <= '0;
            end else if (issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            inflight_q <= inflight_q + IW'(issue) - IW'(ret);
            vld_q[0]   <= issue;
            tag_q[0]   <= '{id: rd_ptr_q, mask: issue_mask};
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end

    pos_sweep_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ret),
        .pop   (pop),
        .din   ({ret_tag, pos_masked}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );
endmodule

// File: tb/tb_pos_cache_sweep_reader.sv
// tb_pos_cache_sweep_reader: randomized sweeps against a cache model and an
// id/mask/position reference derived directly from the per-cell counts.
module tb_pos_cache_sweep_reader;
    localparam int NC = 14, AW = 7, OW = 29, DW = 3 * OW, LAT = 2, DEPTH = LAT + 2;

    logic clk = 0, rst_n = 0, start = 0, out_ready = 0;
    logic [NC*AW-1:0] cell_count = '0;
    logic busy, done, cache_rden, out_valid;
    logic [AW-1:0] cache_addr, out_particle_id;
    logic [NC*DW-1:0] cache_q = '0, d1 = '0, out_pos_data, hold_data;
    logic [NC-1:0] out_cell_mask, hold_mask;
    logic [AW-1:0] hold_id;

    int checks = 0, failures = 0, cyc = 0;
    int cnt_c [NC];
    int seed_a = 0, seed_b = 0, ready_pct = 100;
    int n_res, n_done, first_valid, done_cyc, last_pop, start_cyc, issued, popped, max_out;
    bit mon_en = 0, stall_q = 0;

    pos_cache_sweep_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cell_count(cell_count),
        .busy(busy), .done(done), .cache_addr(cache_addr), .cache_rden(cache_rden),
        .cache_q(cache_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_particle_id(out_particle_id), .out_cell_mask(out_cell_mask), .out_pos_data(out_pos_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pos_f(input int c, input int a);
        return {OW'(c * 977 + a + seed_a), OW'((a * 31) ^ seed_b), OW'(c + a * 14 + 1)};
    endfunction

    function automatic logic [NC*DW-1:0] model_row(input int a);
        logic [NC*DW-1:0] r;
        for (int c = 0; c < NC; c++) r[c*DW +: DW] = pos_f(c, a);
        return r;
    endfunction

    function automatic logic [NC*DW-1:0] rnd_row();
        logic [NC*DW-1:0] r;
        for (int c = 0; c < NC; c++) r[c*DW +: DW] = DW'({$urandom, $urandom, $urandom});
        return r;
    endfunction

    function automatic logic [NC-1:0] exp_mask(input int id);
        logic [NC-1:0] m;
        for (int c = 0; c < NC; c++) m[c] = id < cnt_c[c];
        return m;
    endfunction

    // Two-stage cache read: data for the address presented with rden appears two cycles later.
    always @(posedge clk) begin
        d1 <= cache_rden ? model_row(int'(cache_addr)) : rnd_row();
        cache_q <= d1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = $urandom_range(99) < ready_pct;
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        if (cache_rden) issued++;
        if (issued - popped > max_out) max_out = issued - popped;
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (stall_q) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_id", out_particle_id, hold_id);
            chk("hold_mask", out_cell_mask, hold_mask);
            chk("hold_data", out_pos_data == hold_data, 1);
        end
        stall_q   = out_valid && !out_ready;
        hold_id   = out_particle_id;
        hold_mask = out_cell_mask;
        hold_data = out_pos_data;
        if (out_valid && out_ready) begin
            chk("id", out_particle_id, n_res);
            chk("mask", out_cell_mask, exp_mask(n_res));
            for (int c = 0; c < NC; c++)
                chk($sformatf("pos%0d", c), out_pos_data[c*DW +: DW], exp_mask(n_res)[c] ? pos_f(c, n_res) : '0);
            n_res++;
            popped++;
            last_pop = cyc;
        end
    end

    task automatic chk_zero(input string t);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, done, 0);
        chk({t, "_rden"}, cache_rden, 0);
        chk({t, "_addr"}, cache_addr, 0);
        chk({t, "_valid"}, out_valid, 0);
        chk({t, "_id"}, out_particle_id, 0);
        chk({t, "_mask"}, out_cell_mask, 0);
        chk({t, "_data"}, out_pos_data == '0, 1);
    endtask

    task automatic prep_and_start(input int rdy);
        for (int c = 0; c < NC; c++) cell_count[c*AW +: AW] = AW'(cnt_c[c]);
        seed_a = $urandom;
        seed_b = $urandom;
        ready_pct = rdy;
        n_res = 0; n_done = 0; first_valid = -1; done_cyc = -1; last_pop = -1;
        issued = 0; popped = 0; max_out = 0; stall_q = 0;
        mon_en = 1;
        @(posedge clk);
        #1;
        start = 1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic run(input int rdy, input bit ghost);
        int mx = 0, t = 0;
        foreach (cnt_c[c]) if (cnt_c[c] > mx) mx = cnt_c[c];
        prep_and_start(rdy);
        if (ghost) begin
            @(posedge clk); #1; start = 1;
            @(posedge clk); #1; start = 0;
            while (cyc < start_cyc + 7) begin @(posedge clk); #1; end
            start = 1;
            @(posedge clk); #1; start = 0;
        end
        while (n_done == 0 && t < 5000) begin @(posedge clk); t++; end
        if (t >= 5000) chk("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("results", n_res, mx);
        chk("done_pulses", n_done, 1);
        chk("credit", max_out <= DEPTH, 1);
        chk("busy_after", busy, 0);
        if (mx > 0) begin
            chk("first_valid_lat", first_valid - start_cyc, 4);
            chk("done_after_pop", done_cyc - last_pop, 1);
            chk("reads", issued, mx);
        end else begin
            chk("done_lat", done_cyc - start_cyc, 2);
            chk("no_rden", issued, 0);
            chk("no_valid", first_valid < 0, 1);
        end
        mon_en = 0;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1;
        foreach (cnt_c[c]) cnt_c[c] = 3;
        run(100, 1);
        cnt_c = '{default: 0};
        cnt_c[0] = 5;
        cnt_c[1] = 2;
        run(100, 0);
        cnt_c = '{default: 0};
        run(100, 0);
        foreach (cnt_c[c]) cnt_c[c] = $urandom_range(0, 127);
        cnt_c[0] = 127;
        run(50, 0);
        for (int k = 0; k < 3; k++) begin
            foreach (cnt_c[c]) cnt_c[c] = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60);
            run($urandom_range(30, 100), 0);
        end
        foreach (cnt_c[c]) cnt_c[c] = 127;
        prep_and_start(100);
        t = 0;
        while (!(out_valid && out_particle_id == 7'd40) && t < 2000) begin @(negedge clk); t++; end
        chk("mid_id40_seen", t < 2000, 1);
        mon_en = 0;
        rst_n = 0;
        #1;
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("midrst_hold");
        rst_n = 1;
        foreach (cnt_c[c]) cnt_c[c] = 4;
        run(100, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
